// File: rtl/pipeline_hazard_unit.sv
// Forwarding and load-use interlock unit at the ID stage, tracking EX/MEM destination tags.
// Optional HAZARD_PERF_EN adds saturating stall/forward event counters.
module pipeline_hazard_unit #(
    parameter int AW           = 5,
    parameter int DW           = 64,
    parameter int NUM_SRC      = 2,
    parameter int ZERO_REG     = 31,
    parameter int FWD_MEM_LOAD = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NUM_SRC*AW-1:0]  id_src,
    input  logic [NUM_SRC-1:0]     id_src_used,
    input  logic [NUM_SRC*DW-1:0]  id_rdata,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic [DW-1:0]          ex_result,
    input  logic [DW-1:0]          mem_result,
    input  logic                   flush,
    output logic                   stall,
    output logic                   bubble,
    output logic [NUM_SRC*2-1:0]   fwd_sel,
    output logic [NUM_SRC*DW-1:0]  fwd_data
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]            perf_stall,
    output logic [31:0]            perf_fwd_ex,
    output logic [31:0]            perf_fwd_mem
`endif
);

    localparam logic [AW-1:0] ZERO_IDX       = AW'(ZERO_REG);
    localparam logic          MEM_LOAD_STALL = (FWD_MEM_LOAD == 0);

    logic          ex_v, mem_v;
    logic [AW-1:0] ex_rd, mem_rd;
    logic          ex_ld, mem_ld;

    logic [NUM_SRC-1:0] ex_match, mem_match;
    logic               any_fwd_ex, any_fwd_mem;

    always_comb begin
        ex_match  = '0;
        mem_match = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_match[i]  = id_valid & id_src_used[i] & (id_src[i*AW +: AW] != ZERO_IDX)
                           & ex_v & (ex_rd == id_src[i*AW +: AW]);
            mem_match[i] = id_valid & id_src_used[i] & (id_src[i*AW +: AW] != ZERO_IDX)
                           & mem_v & (mem_rd == id_src[i*AW +: AW]);
        end
    end

    // A flushed instruction never interlocks; it is squashed regardless of hazards.
    always_comb begin
        stall  = ~flush & ((ex_ld & (|ex_match)) | (MEM_LOAD_STALL & mem_ld & (|mem_match)));
        bubble = stall | flush;
    end

    // EX beats MEM; a load still in EX has no data yet, so it falls through (and stalls).
    always_comb begin
        fwd_sel     = '0;
        fwd_data    = id_rdata;
        any_fwd_ex  = 1'b0;
        any_fwd_mem = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_match[i] && !ex_ld) begin
                fwd_sel[i*2 +: 2]   = 2'b01;
                fwd_data[i*DW +: DW] = ex_result;
                any_fwd_ex          = 1'b1;
            end else if (mem_match[i]) begin
                fwd_sel[i*2 +: 2]   = 2'b10;
                fwd_data[i*DW +: DW] = mem_result;
                any_fwd_mem         = 1'b1;
            end
        end
    end

    // ---- ID -> EX -> MEM tag pipeline: valids are reset, tag payload is not ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_v  <= 1'b0;
            mem_v <= 1'b0;
        end else begin
            ex_v  <= id_valid & id_regwrite & ~stall & ~flush;
            mem_v <= ex_v;
        end
    end

    always_ff @(posedge clk) begin
        ex_rd  <= id_rd;
        ex_ld  <= id_is_load;
        mem_rd <= ex_rd;
        mem_ld <= ex_ld;
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        if (en && cnt != 32'hFFFF_FFFF)
            return cnt + 32'd1;
        return cnt;
    endfunction

    logic id_active;
    assign id_active = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall   <= '0;
            perf_fwd_ex  <= '0;
            perf_fwd_mem <= '0;
        end else begin
            perf_stall   <= sat_inc(perf_stall, stall);
            perf_fwd_ex  <= sat_inc(perf_fwd_ex, id_active & any_fwd_ex);
            perf_fwd_mem <= sat_inc(perf_fwd_mem, id_active & any_fwd_mem);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: one instance with MEM load forwarding, one without,
// driven by the same ID stream; expectations queued at drive time and popped at the sample point.
module tb_pipeline_hazard_unit;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NS = 2;

    localparam logic [DW-1:0] RF0 = 64'h1000_0000_0000_00A0;
    localparam logic [DW-1:0] RF1 = 64'h2000_0000_0000_00B0;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [NS*AW-1:0]  id_src;
    logic [NS-1:0]     id_src_used;
    logic [NS*DW-1:0]  id_rdata;
    logic [AW-1:0]     id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic [DW-1:0]     ex_result;
    logic [DW-1:0]     mem_result;
    logic              flush;

    logic              stall, bubble;
    logic [NS*2-1:0]   fwd_sel;
    logic [NS*DW-1:0]  fwd_data;
    logic              s_stall, s_bubble;
    logic [NS*2-1:0]   s_fwd_sel;
    logic [NS*DW-1:0]  s_fwd_data;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_fwd_ex, perf_fwd_mem;
    logic [31:0] s_perf_stall, s_perf_fwd_ex, s_perf_fwd_mem;
`endif

    pipeline_hazard_unit #(.AW(AW), .DW(DW), .NUM_SRC(NS), .ZERO_REG(31), .FWD_MEM_LOAD(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_rdata(id_rdata), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_result(ex_result), .mem_result(mem_result), .flush(flush),
        .stall(stall), .bubble(bubble), .fwd_sel(fwd_sel), .fwd_data(fwd_data)
`ifdef HAZARD_PERF_EN
        , .perf_stall(perf_stall), .perf_fwd_ex(perf_fwd_ex), .perf_fwd_mem(perf_fwd_mem)
`endif
    );

    pipeline_hazard_unit #(.AW(AW), .DW(DW), .NUM_SRC(NS), .ZERO_REG(31), .FWD_MEM_LOAD(0)) dut_slow (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_rdata(id_rdata), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .ex_result(ex_result), .mem_result(mem_result), .flush(flush),
        .stall(s_stall), .bubble(s_bubble), .fwd_sel(s_fwd_sel), .fwd_data(s_fwd_data)
`ifdef HAZARD_PERF_EN
        , .perf_stall(s_perf_stall), .perf_fwd_ex(s_perf_fwd_ex), .perf_fwd_mem(s_perf_fwd_mem)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        logic           stall;
        logic           bubble;
        logic [3:0]     sel;
        logic           chk_sel;
        logic [DW-1:0]  d0;
        logic [DW-1:0]  d1;
        logic [1:0]     chk_d;
        logic           s_stall;
        logic           s_bubble;
        logic [3:0]     s_sel;
        logic           chk_s_sel;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                         input logic [1:0] used, input logic [AW-1:0] rd, input logic rw,
                         input logic ld, input logic fl);
        @(negedge clk);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_is_load  = ld;
        flush       = fl;
    endtask

    task automatic push(input string tag, input logic st, input logic bb, input logic [3:0] sel,
                        input logic csel, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [1:0] cd, input logic sst, input logic sbb,
                        input logic [3:0] ssel, input logic cssel);
        exp_t e;
        e.tag = tag; e.stall = st; e.bubble = bb; e.sel = sel; e.chk_sel = csel;
        e.d0 = d0; e.d1 = d1; e.chk_d = cd;
        e.s_stall = sst; e.s_bubble = sbb; e.s_sel = ssel; e.chk_s_sel = cssel;
        sb.push_back(e);
    endtask

    task automatic sample(input int dly);
        exp_t e;
        #(dly);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".stall"},  {63'd0, stall},  {63'd0, e.stall});
        chk({e.tag, ".bubble"}, {63'd0, bubble}, {63'd0, e.bubble});
        if (e.chk_sel) chk({e.tag, ".sel"}, {60'd0, fwd_sel}, {60'd0, e.sel});
        if (e.chk_d[0]) chk({e.tag, ".data0"}, fwd_data[0 +: DW], e.d0);
        if (e.chk_d[1]) chk({e.tag, ".data1"}, fwd_data[DW +: DW], e.d1);
        chk({e.tag, ".slow_stall"},  {63'd0, s_stall},  {63'd0, e.s_stall});
        chk({e.tag, ".slow_bubble"}, {63'd0, s_bubble}, {63'd0, e.s_bubble});
        if (e.chk_s_sel) chk({e.tag, ".slow_sel"}, {60'd0, s_fwd_sel}, {60'd0, e.s_sel});
    endtask

    initial begin
        reset       = 1'b0;
        id_valid    = 1'b0;
        id_src      = '0;
        id_src_used = '0;
        id_rdata    = {RF1, RF0};
        id_rd       = '0;
        id_regwrite = 1'b0;
        id_is_load  = 1'b0;
        ex_result   = 64'd5;
        mem_result  = 64'hDEAD;
        flush       = 1'b0;

        // reset state, ID reading X1/X2 with nothing in flight
        drive(1, 5'd1, 5'd2, 2'b11, 5'd0, 0, 0, 0);
        push("reset", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        @(negedge clk);
        reset = 1'b1;

        // ADDI X1,X31,#5
        drive(1, 5'd31, 5'd0, 2'b01, 5'd1, 1, 0, 0);
        push("addi_x1", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        // ADD X2,X1,X1 -> both from EX
        drive(1, 5'd1, 5'd1, 2'b11, 5'd2, 1, 0, 0);
        push("ex_fwd_both", 0, 0, 4'b0101, 1, 64'd5, 64'd5, 2'b11, 0, 0, 4'b0101, 1);
        sample(2);
        // LDUR X3,[X2] -> port0 from EX, port1 unused
        drive(1, 5'd2, 5'd0, 2'b01, 5'd3, 1, 1, 0);
        push("ldur_x3", 0, 0, 4'b0001, 1, 64'd5, RF1, 2'b11, 0, 0, 4'b0001, 1);
        sample(2);
        // ADD X4,X3,X0 -> load-use stall
        drive(1, 5'd3, 5'd0, 2'b11, 5'd4, 1, 0, 0);
        push("load_use", 1, 1, 4'b0000, 0, RF0, RF1, 2'b00, 1, 1, 4'b0000, 0);
        sample(2);
        // held: fast unit forwards load from MEM, slow unit keeps stalling
        drive(1, 5'd3, 5'd0, 2'b11, 5'd4, 1, 0, 0);
        push("load_mem_fwd", 0, 0, 4'b0010, 1, 64'hDEAD, RF1, 2'b11, 1, 1, 4'b0000, 0);
        sample(2);
        drive(1, 5'd3, 5'd0, 2'b11, 5'd4, 1, 0, 0);
        push("slow_release", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        // invalid ID never matches
        drive(0, 5'd4, 5'd4, 2'b11, 5'd4, 1, 0, 0);
        push("id_invalid", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        // writer to X31, then reader of X31
        drive(1, 5'd0, 5'd0, 2'b00, 5'd31, 1, 0, 0);
        push("wr_x31", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        drive(1, 5'd31, 5'd31, 2'b11, 5'd5, 1, 0, 0);
        push("rd_x31", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        // X4 writers into EX and MEM; X5 from MEM on the way
        drive(1, 5'd0, 5'd0, 2'b00, 5'd4, 1, 0, 0);
        push("wr_x4_a", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        drive(1, 5'd5, 5'd0, 2'b01, 5'd4, 1, 0, 0);
        push("mem_fwd_x5", 0, 0, 4'b0010, 1, 64'hDEAD, RF1, 2'b11, 0, 0, 4'b0010, 1);
        sample(2);
        ex_result  = 64'h11;
        mem_result = 64'h22;
        drive(1, 5'd4, 5'd4, 2'b11, 5'd6, 0, 0, 0);
        push("ex_over_mem", 0, 0, 4'b0101, 1, 64'h11, 64'h11, 2'b11, 0, 0, 4'b0101, 1);
        sample(2);
        // port1 only from MEM; this ID is LDUR X3
        drive(1, 5'd4, 5'd4, 2'b10, 5'd3, 1, 1, 0);
        push("port1_mem", 0, 0, 4'b1000, 1, RF0, 64'h22, 2'b11, 0, 0, 4'b1000, 1);
        sample(2);
        // load-use squashed by flush
        drive(1, 5'd3, 5'd0, 2'b01, 5'd7, 1, 0, 1);
        push("flush_wins", 0, 1, 4'b0000, 1, RF0, RF1, 2'b11, 0, 1, 4'b0000, 1);
        sample(2);
        // flushed X7 writer left no tag; this ID is LDUR X8
        drive(1, 5'd7, 5'd0, 2'b01, 5'd8, 1, 1, 0);
        push("no_tag_after_flush", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);
        // load-use on X8, then asynchronous reset mid-stall
        drive(1, 5'd8, 5'd0, 2'b01, 5'd9, 1, 0, 0);
        push("stall_pre_reset", 1, 1, 4'b0000, 0, RF0, RF1, 2'b00, 1, 1, 4'b0000, 0);
        sample(2);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_cnt", {32'd0, perf_stall}, 64'd1);
        chk("perf_fwd_ex_cnt", {32'd0, perf_fwd_ex}, 64'd3);
        chk("perf_fwd_mem_cnt", {32'd0, perf_fwd_mem}, 64'd3);
`endif
        reset = 1'b0;
        push("async_reset", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(1);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_rst", {32'd0, perf_stall}, 64'd0);
        chk("perf_fwd_ex_rst", {32'd0, perf_fwd_ex}, 64'd0);
        chk("perf_fwd_mem_rst", {32'd0, perf_fwd_mem}, 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        drive(1, 5'd8, 5'd0, 2'b01, 5'd9, 1, 0, 0);
        push("after_reset", 0, 0, 4'b0000, 1, RF0, RF1, 2'b11, 0, 0, 4'b0000, 1);
        sample(2);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
